// File: rtl/apb_periph_node.sv
// APB3 peripheral node: decodes NB_SLAVES 4 KB windows and forwards each transfer to one slave.
// Define APB_PERIPH_NODE_TIMEOUT_EN to abort access phases that exceed TIMEOUT_CYCLES.
//
// state  | meaning
// IDLE   | waiting for an upstream setup phase
// SETUP  | downstream psel asserted, penable low
// ACCESS | downstream psel and penable high, waiting for the slave's pready
// RESP   | slave response returned upstream
// ERR    | decode miss or timeout, error returned upstream
module apb_periph_node #(
  parameter int unsigned NB_SLAVES       = 4,
  parameter int unsigned APB_ADDR_WIDTH  = 32,
  parameter int unsigned APB_DATA_WIDTH  = 32,
  parameter int unsigned SLAVE_ADDR_BITS = 12,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR = 32'h1A10_0000,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                s_psel,
  input  logic                                s_penable,
  input  logic                                s_pwrite,
  input  logic [APB_ADDR_WIDTH-1:0]           s_paddr,
  input  logic [APB_DATA_WIDTH-1:0]           s_pwdata,
  output logic [APB_DATA_WIDTH-1:0]           s_prdata,
  output logic                                s_pready,
  output logic                                s_pslverr,
  output logic [NB_SLAVES-1:0]                m_psel,
  output logic                                m_penable,
  output logic                                m_pwrite,
  output logic [APB_ADDR_WIDTH-1:0]           m_paddr,
  output logic [APB_DATA_WIDTH-1:0]           m_pwdata,
  input  logic [NB_SLAVES*APB_DATA_WIDTH-1:0] m_prdata,
  input  logic [NB_SLAVES-1:0]                m_pready,
  input  logic [NB_SLAVES-1:0]                m_pslverr,
  output logic                                timeout_o,
  output logic [7:0]                          err_count_o
);

  if (NB_SLAVES < 1 || NB_SLAVES > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("apb_periph_node: illegal parameter value");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP, ST_ERR} state_t;

  state_t                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, offs, win;
  logic [APB_DATA_WIDTH-1:0] wdata_q, rdata_q, sel_rdata;
  logic                      write_q, slverr_q;
  logic [NB_SLAVES-1:0]      sel_q, dec_sel;
  logic [7:0]                err_cnt_q;
  logic                      hit, start, sel_ready, sel_err, timeout_hit;

  assign start     = s_psel & ~s_penable;
  assign sel_ready = |(m_pready & sel_q);
  assign sel_err   = |(m_pslverr & sel_q);

  always_comb begin
    offs = s_paddr - BASE_ADDR;
    win  = offs >> SLAVE_ADDR_BITS;
    hit  = (s_paddr >= BASE_ADDR) && (win < APB_ADDR_WIDTH'(NB_SLAVES));
    for (int i = 0; i < NB_SLAVES; i++) begin
      dec_sel[i] = hit && (win == APB_ADDR_WIDTH'(i));
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NB_SLAVES; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | m_prdata[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    end
  end

`ifdef APB_PERIPH_NODE_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] tcnt_q;
  logic            to_q;

  // Down-counter loaded in SETUP; terminal count reached after TIMEOUT_CYCLES access cycles.
  assign timeout_hit = (tcnt_q == '0) && !sel_ready;
  assign timeout_o   = (state_q == ST_ERR) && to_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      if (state_q == ST_SETUP) begin
        tcnt_q <= TO_W'(TIMEOUT_CYCLES - 1);
      end else if (state_q == ST_ACCESS && !sel_ready && tcnt_q != '0) begin
        tcnt_q <= tcnt_q - 1'b1;
      end
      if (state_q == ST_IDLE) begin
        to_q <= 1'b0;
      end else if (state_q == ST_ACCESS && timeout_hit) begin
        to_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = hit ? ST_SETUP : ST_ERR;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready) state_d = ST_RESP;
        else if (timeout_hit) state_d = ST_ERR;
      end
      ST_RESP:   state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_psel      = '0;
    m_penable   = 1'b0;
    s_pready    = 1'b0;
    s_pslverr   = 1'b0;
    s_prdata    = '0;
    m_pwrite    = write_q;
    m_paddr     = addr_q;
    m_pwdata    = wdata_q;
    err_count_o = err_cnt_q;
    case (state_q)
      ST_SETUP:  m_psel = sel_q;
      ST_ACCESS: begin
        m_psel    = sel_q;
        m_penable = 1'b1;
      end
      ST_RESP: begin
        s_pready  = 1'b1;
        s_pslverr = slverr_q;
        s_prdata  = rdata_q;
      end
      ST_ERR: begin
        s_pready  = 1'b1;
        s_pslverr = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      sel_q     <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        addr_q  <= s_paddr;
        wdata_q <= s_pwdata;
        write_q <= s_pwrite;
        sel_q   <= dec_sel;
      end
      if (state_q == ST_ACCESS && sel_ready) begin
        rdata_q  <= sel_rdata;
        slverr_q <= sel_err;
      end
      if (state_q == ST_ERR && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

endmodule
